// File: rtl/multi_channel_timer.sv
// Multi-channel hh:mm:ss BCD timer: countdown or count-up per channel with optional auto-reload.
// Shared command and display ports are steered by ch_sel; one prescaler paces every channel.
module multi_channel_timer #(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SEL_W    = 2
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic                set,
  input  logic                play,
  input  logic                stop,
  input  logic                ring_clr,
  input  logic                mode_up,
  input  logic                auto_reload,
  input  logic [7:0]          hour_bcd_in,
  input  logic [7:0]          minute_bcd_in,
  input  logic [7:0]          second_bcd_in,
  output logic [7:0]          hour_out_bcd,
  output logic [7:0]          minute_out_bcd,
  output logic [7:0]          second_out_bcd,
  output logic [CHANNELS-1:0] ring,
  output logic [CHANNELS-1:0] counting,
  output logic                any_ring,
  output logic                set_err
);

  localparam int          PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [23:0] MAX_VAL = 24'h99_59_59;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  // Two-digit BCD helpers; 'top' is the largest legal value of the pair.
  function automatic logic [7:0] dec_pair(input logic [7:0] v, input logic [7:0] top);
    if (v == 8'h00) return top;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] inc_pair(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic borrow_s, borrow_m;
    borrow_s = (v[7:0] == 8'h00);
    borrow_m = borrow_s && (v[15:8] == 8'h00);
    return {borrow_m ? dec_pair(v[23:16], 8'h99) : v[23:16],
            borrow_s ? dec_pair(v[15:8], 8'h59)  : v[15:8],
            dec_pair(v[7:0], 8'h59)};
  endfunction

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic carry_s, carry_m;
    carry_s = (v[7:0] == 8'h59);
    carry_m = carry_s && (v[15:8] == 8'h59);
    return {carry_m ? inc_pair(v[23:16], 8'h99) : v[23:16],
            carry_s ? inc_pair(v[15:8], 8'h59)  : v[15:8],
            inc_pair(v[7:0], 8'h59)};
  endfunction

  function automatic logic bcd_ok(input logic [23:0] v);
    return (v[23:20] <= 4'd9) && (v[19:16] <= 4'd9) &&
           (v[15:12] <= 4'd5) && (v[11:8]  <= 4'd9) &&
           (v[7:4]   <= 4'd5) && (v[3:0]   <= 4'd9);
  endfunction

  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)    presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end

  logic [23:0]         val_q  [CHANNELS];
  logic [23:0]         val_d  [CHANNELS];
  logic [23:0]         copy_q [CHANNELS];
  logic [23:0]         copy_d [CHANNELS];
  state_t              state_q[CHANNELS];
  state_t              state_d[CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d, reload_q, reload_d, ring_q, ring_d;
  logic [23:0]         load_val, step_val, disp_d;
  logic                load_ok, sel, set_err_d;

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    load_val  = {hour_bcd_in, minute_bcd_in, second_bcd_in};
    load_ok   = bcd_ok(load_val);
    set_err_d = 1'b0;
    step_val  = '0;
    sel       = 1'b0;
    mode_d    = mode_q;
    reload_d  = reload_q;
    ring_d    = ring_q;
    for (int i = 0; i < CHANNELS; i++) begin
      val_d[i]   = val_q[i];
      copy_d[i]  = copy_q[i];
      state_d[i] = state_q[i];
      sel        = (ch_sel == SEL_W'(i));

      // Cleared first so a ring raised below in the same cycle overrides the clear.
      if (sel && ring_clr) ring_d[i] = 1'b0;

      if (sel && set) begin
        if (load_ok) begin
          val_d[i]    = load_val;
          copy_d[i]   = load_val;
          mode_d[i]   = mode_up;
          reload_d[i] = auto_reload;
          ring_d[i]   = 1'b0;
          state_d[i]  = ST_IDLE;
        end else begin
          set_err_d = 1'b1;
        end
      end else if (sel && stop) begin
        if (state_q[i] == ST_RUN) state_d[i] = ST_PAUSE;
      end else if (sel && play) begin
        if (state_q[i] == ST_IDLE || state_q[i] == ST_PAUSE) begin
          if (!mode_q[i] && val_q[i] == '0) begin
            state_d[i] = ST_DONE;
            ring_d[i]  = 1'b1;
          end else begin
            state_d[i] = ST_RUN;
          end
        end
      end else if (tick && state_q[i] == ST_RUN) begin
        if (mode_q[i]) begin
          step_val = (val_q[i] == MAX_VAL) ? MAX_VAL : bcd_inc(val_q[i]);
          val_d[i] = step_val;
          if (step_val == MAX_VAL) begin
            ring_d[i]  = 1'b1;
            state_d[i] = ST_DONE;
          end
        end else begin
          step_val = bcd_dec(val_q[i]);
          val_d[i] = step_val;
          if (step_val == '0) begin
            ring_d[i] = 1'b1;
            if (reload_q[i] && copy_q[i] != '0) val_d[i]   = copy_q[i];
            else                                 state_d[i] = ST_DONE;
          end
        end
      end
    end

    disp_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == SEL_W'(i)) disp_d = val_q[i];
    end
  end

  // NOTE: the per-channel arrays are small control registers whose reset value is
  // architecturally visible, so they are reset like any other flop, not left as RAM.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        val_q[i]   <= '0;
        copy_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
      end
      mode_q         <= '0;
      reload_q       <= '0;
      ring_q         <= '0;
      set_err        <= 1'b0;
      hour_out_bcd   <= '0;
      minute_out_bcd <= '0;
      second_out_bcd <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        val_q[i]   <= val_d[i];
        copy_q[i]  <= copy_d[i];
        state_q[i] <= state_d[i];
      end
      mode_q         <= mode_d;
      reload_q       <= reload_d;
      ring_q         <= ring_d;
      set_err        <= set_err_d;
      hour_out_bcd   <= disp_d[23:16];
      minute_out_bcd <= disp_d[15:8];
      second_out_bcd <= disp_d[7:0];
    end
  end

  always_comb begin
    counting = '0;
    for (int i = 0; i < CHANNELS; i++) counting[i] = (state_q[i] == ST_RUN);
  end

  assign ring     = ring_q;
  assign any_ring = |ring_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Bench for multi_channel_timer: directed scenarios plus random commands, checked against
// a reference model that tracks each channel as a plain count of seconds.
module tb_multi_channel_timer;
  localparam int CH   = 4;
  localparam int TD   = 10;
  localparam int SW   = 2;
  localparam int MAXS = 99 * 3600 + 59 * 60 + 59;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic          clk_50M, rst_n;
  logic [SW-1:0] ch_sel;
  logic          set, play, stop, ring_clr, mode_up, auto_reload;
  logic [7:0]    hour_bcd_in, minute_bcd_in, second_bcd_in;
  logic [7:0]    hour_out_bcd, minute_out_bcd, second_out_bcd;
  logic [CH-1:0] ring, counting;
  logic          any_ring, set_err;
  logic [23:0]   dut_disp;

  int total = 0;
  int bad   = 0;

  multi_channel_timer #(.CHANNELS(CH), .TICK_DIV(TD), .SEL_W(SW)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .ch_sel(ch_sel),
    .set(set), .play(play), .stop(stop), .ring_clr(ring_clr),
    .mode_up(mode_up), .auto_reload(auto_reload),
    .hour_bcd_in(hour_bcd_in), .minute_bcd_in(minute_bcd_in), .second_bcd_in(second_bcd_in),
    .hour_out_bcd(hour_out_bcd), .minute_out_bcd(minute_out_bcd), .second_out_bcd(second_out_bcd),
    .ring(ring), .counting(counting), .any_ring(any_ring), .set_err(set_err)
  );

  assign dut_disp = {hour_out_bcd, minute_out_bcd, second_out_bcd};

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // ---------------- reference model ----------------
  int m_secs[CH], m_copy[CH], m_st[CH];
  bit m_up[CH], m_rel[CH], m_ring[CH];
  int m_presc, m_disp;
  bit m_err;

  function automatic int bcd_to_int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] secs_to_bcd(input int s);
    return {int_to_bcd(s / 3600), int_to_bcd((s / 60) % 60), int_to_bcd(s % 60)};
  endfunction

  function automatic logic [CH-1:0] exp_ring();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_ring[i];
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_counting();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (m_st[i] == S_RUN);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_secs[i] = 0; m_copy[i] = 0; m_st[i] = S_IDLE;
      m_up[i] = 0; m_rel[i] = 0; m_ring[i] = 0;
    end
    m_presc = 0; m_disp = 0; m_err = 0;
  endtask

  // Advances the model by the clock edge about to happen, using the inputs now applied.
  task automatic model_eval();
    bit tick, ok, sel;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick    = (m_presc == TD - 1);
    m_presc = tick ? 0 : m_presc + 1;
    m_disp  = m_secs[ch_sel];
    m_err   = 0;
    ok = (hour_bcd_in[7:4] <= 9) && (hour_bcd_in[3:0] <= 9) &&
         (minute_bcd_in[3:0] <= 9) && (second_bcd_in[3:0] <= 9) &&
         (bcd_to_int(minute_bcd_in) <= 59) && (bcd_to_int(second_bcd_in) <= 59);
    for (int i = 0; i < CH; i++) begin
      sel = (int'(ch_sel) == i);
      if (sel && ring_clr) m_ring[i] = 0;
      if (sel && set) begin
        if (ok) begin
          m_secs[i] = bcd_to_int(hour_bcd_in) * 3600 + bcd_to_int(minute_bcd_in) * 60 +
                      bcd_to_int(second_bcd_in);
          m_copy[i] = m_secs[i];
          m_up[i] = mode_up; m_rel[i] = auto_reload; m_ring[i] = 0; m_st[i] = S_IDLE;
        end else m_err = 1;
      end else if (sel && stop) begin
        if (m_st[i] == S_RUN) m_st[i] = S_PAUSE;
      end else if (sel && play) begin
        if (m_st[i] == S_IDLE || m_st[i] == S_PAUSE) begin
          if (!m_up[i] && m_secs[i] == 0) begin m_st[i] = S_DONE; m_ring[i] = 1; end
          else m_st[i] = S_RUN;
        end
      end else if (tick && m_st[i] == S_RUN) begin
        if (m_up[i]) begin
          if (m_secs[i] < MAXS) m_secs[i]++;
          if (m_secs[i] == MAXS) begin m_ring[i] = 1; m_st[i] = S_DONE; end
        end else begin
          m_secs[i]--;
          if (m_secs[i] == 0) begin
            m_ring[i] = 1;
            if (m_rel[i] && m_copy[i] != 0) m_secs[i] = m_copy[i];
            else m_st[i] = S_DONE;
          end
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    model_eval();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic pulse_set(input int ch, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input bit up, input bit rel);
    ch_sel = SW'(ch); hour_bcd_in = h; minute_bcd_in = m; second_bcd_in = s;
    mode_up = up; auto_reload = rel; set = 1'b1;
    cyc();
    set = 1'b0;
  endtask

  task automatic pulse_play(input int ch);
    ch_sel = SW'(ch); play = 1'b1; cyc(); play = 1'b0;
  endtask

  task automatic pulse_stop(input int ch);
    ch_sel = SW'(ch); stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic pulse_clr(input int ch);
    ch_sel = SW'(ch); ring_clr = 1'b1; cyc(); ring_clr = 1'b0;
  endtask

  task automatic wait_change(input logic [23:0] from, input int budget, output int waited);
    waited = 0;
    while (dut_disp === from && waited < budget) begin
      cyc();
      waited++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #35;
    total++;
    if (dut_disp !== 24'h0) begin bad++; $display("FAIL reset_display: got %h expected 000000", dut_disp); end
    total++;
    if (ring !== '0 || counting !== '0 || any_ring !== 1'b0 || set_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got ring=%b counting=%b any=%b err=%b expected zeros",
                      ring, counting, any_ring, set_err);
    end
    model_reset();
    @(posedge clk_50M); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_countdown();
    logic [23:0] exp_seq[3];
    logic [23:0] prev;
    int w;
    exp_seq[0] = 24'h000002; exp_seq[1] = 24'h000001; exp_seq[2] = 24'h000000;
    pulse_set(0, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0);
    pulse_play(0);
    prev = 24'h000003;
    for (int k = 0; k < 3; k++) begin
      wait_change(prev, 2 * TD + 2, w);
      total++;
      if (dut_disp !== exp_seq[k]) begin
        bad++; $display("FAIL countdown_value[%0d]: got %h expected %h", k, dut_disp, exp_seq[k]);
      end
      if (k > 0) begin
        total++;
        if (w != TD) begin bad++; $display("FAIL countdown_interval[%0d]: got %0d expected %0d", k, w, TD); end
      end
      prev = exp_seq[k];
    end
    total++;
    if (ring[0] !== 1'b1 || any_ring !== 1'b1) begin
      bad++; $display("FAIL countdown_ring: got ring0=%b any=%b expected 1 1", ring[0], any_ring);
    end
    total++;
    if (counting[0] !== 1'b0) begin bad++; $display("FAIL countdown_counting: got %b expected 0", counting[0]); end
    repeat (3 * TD) cyc();
    total++;
    if (dut_disp !== 24'h0) begin bad++; $display("FAIL countdown_hold: got %h expected 000000", dut_disp); end
  endtask

  task automatic test_borrow();
    int w;
    pulse_set(0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    pulse_play(0);
    wait_change(24'h010000, 2 * TD + 2, w);
    total++;
    if (dut_disp !== 24'h005959) begin bad++; $display("FAIL borrow_chain: got %h expected 005959", dut_disp); end
    pulse_stop(0);
  endtask

  task automatic test_count_up();
    int w;
    pulse_set(0, 8'h00, 8'h00, 8'h59, 1'b1, 1'b0);
    pulse_play(0);
    wait_change(24'h000059, 2 * TD + 2, w);
    total++;
    if (dut_disp !== 24'h000100) begin bad++; $display("FAIL countup_carry: got %h expected 000100", dut_disp); end
    pulse_set(0, 8'h99, 8'h59, 8'h58, 1'b1, 1'b0);
    pulse_play(0);
    wait_change(24'h995958, 2 * TD + 2, w);
    total++;
    if (dut_disp !== 24'h995959) begin bad++; $display("FAIL countup_max: got %h expected 995959", dut_disp); end
    total++;
    if (ring[0] !== 1'b1 || counting[0] !== 1'b0) begin
      bad++; $display("FAIL countup_done: got ring0=%b counting0=%b expected 1 0", ring[0], counting[0]);
    end
    repeat (3 * TD) cyc();
    total++;
    if (dut_disp !== 24'h995959) begin bad++; $display("FAIL countup_saturate: got %h expected 995959", dut_disp); end
  endtask

  task automatic test_auto_reload();
    logic [23:0] exp_seq[5];
    logic [23:0] prev;
    int w;
    exp_seq[0] = 24'h000001; exp_seq[1] = 24'h000002; exp_seq[2] = 24'h000001;
    exp_seq[3] = 24'h000002; exp_seq[4] = 24'h000001;
    pulse_set(3, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1);
    pulse_play(3);
    prev = 24'h000002;
    for (int k = 0; k < 5; k++) begin
      wait_change(prev, 2 * TD + 2, w);
      total++;
      if (dut_disp !== exp_seq[k]) begin
        bad++; $display("FAIL reload_value[%0d]: got %h expected %h", k, dut_disp, exp_seq[k]);
      end
      total++;
      if (counting[3] !== 1'b1 || ring[3] !== (k >= 1)) begin
        bad++; $display("FAIL reload_flags[%0d]: got counting3=%b ring3=%b expected 1 %0d",
                        k, counting[3], ring[3], (k >= 1));
      end
      prev = exp_seq[k];
    end
    pulse_stop(3);
  endtask

  task automatic test_independent();
    int saved1, saved2, w;
    pulse_set(1, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
    pulse_set(2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    pulse_play(1);
    pulse_play(2);
    repeat (2 * TD) cyc();
    for (int g = 0; g < TD && m_presc != TD - 1; g++) cyc();
    saved1 = m_secs[1];
    saved2 = m_secs[2];
    pulse_stop(1);
    cyc();
    total++;
    if (dut_disp !== secs_to_bcd(saved1)) begin
      bad++; $display("FAIL indep_frozen: got %h expected %h", dut_disp, secs_to_bcd(saved1));
    end
    total++;
    if (counting[1] !== 1'b0 || counting[2] !== 1'b1) begin
      bad++; $display("FAIL indep_counting: got %b expected ch1=0 ch2=1", counting);
    end
    ch_sel = 2'd2;
    cyc();
    total++;
    if (dut_disp !== secs_to_bcd(saved2 + 1)) begin
      bad++; $display("FAIL indep_ch2_step: got %h expected %h", dut_disp, secs_to_bcd(saved2 + 1));
    end
    pulse_play(1);
    w = 0;
    while (ring[1] !== 1'b1 && w < 8 * TD) begin cyc(); w++; end
    total++;
    if (ring[1] !== 1'b1) begin bad++; $display("FAIL indep_ring1_timeout: got %b expected 1", ring[1]); end
    pulse_set(2, 8'h99, 8'h59, 8'h58, 1'b1, 1'b0);
    pulse_play(2);
    w = 0;
    while (ring[2] !== 1'b1 && w < 4 * TD) begin cyc(); w++; end
    total++;
    if (ring[2] !== 1'b1) begin bad++; $display("FAIL indep_ring2_timeout: got %b expected 1", ring[2]); end
    pulse_clr(1);
    total++;
    if (ring[1] !== 1'b0 || ring[2] !== 1'b1) begin
      bad++; $display("FAIL indep_ring_clr: got ring=%b expected ch1=0 ch2=1", ring);
    end
  endtask

  task automatic test_invalid_set();
    pulse_set(1, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    total++;
    if (set_err !== 1'b0) begin bad++; $display("FAIL valid_set_err: got %b expected 0", set_err); end
    pulse_set(1, 8'h00, 8'h60, 8'h00, 1'b1, 1'b1);
    total++;
    if (set_err !== 1'b1) begin bad++; $display("FAIL invalid_min_err: got %b expected 1", set_err); end
    cyc();
    total++;
    if (set_err !== 1'b0) begin bad++; $display("FAIL invalid_err_width: got %b expected 0", set_err); end
    total++;
    if (dut_disp !== 24'h123456 || counting[1] !== 1'b0) begin
      bad++; $display("FAIL invalid_unchanged: got %h counting1=%b expected 123456 0", dut_disp, counting[1]);
    end
    pulse_set(1, 8'h0A, 8'h00, 8'h00, 1'b0, 1'b0);
    total++;
    if (set_err !== 1'b1) begin bad++; $display("FAIL invalid_hour_err: got %b expected 1", set_err); end
  endtask

  task automatic test_same_cycle();
    ch_sel = 2'd0; hour_bcd_in = 8'h00; minute_bcd_in = 8'h00; second_bcd_in = 8'h04;
    mode_up = 1'b0; auto_reload = 1'b0; set = 1'b1; play = 1'b1;
    cyc();
    set = 1'b0; play = 1'b0;
    total++;
    if (counting[0] !== 1'b0) begin bad++; $display("FAIL setplay_idle: got %b expected 0", counting[0]); end
    repeat (2 * TD) cyc();
    total++;
    if (dut_disp !== 24'h000004 || counting[0] !== 1'b0) begin
      bad++; $display("FAIL setplay_hold: got %h counting0=%b expected 000004 0", dut_disp, counting[0]);
    end
  endtask

  task automatic test_play_zero();
    pulse_set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    total++;
    if (ring[0] !== 1'b0) begin bad++; $display("FAIL zero_pre_ring: got %b expected 0", ring[0]); end
    pulse_play(0);
    total++;
    if (ring[0] !== 1'b1 || counting[0] !== 1'b0) begin
      bad++; $display("FAIL zero_play: got ring0=%b counting0=%b expected 1 0", ring[0], counting[0]);
    end
  endtask

  task automatic test_random();
    int kind;
    for (int n = 0; n < 800; n++) begin
      ch_sel      = SW'($urandom_range(0, CH - 1));
      set         = ($urandom_range(0, 99) < 5);
      play        = ($urandom_range(0, 99) < 12);
      stop        = ($urandom_range(0, 99) < 4);
      ring_clr    = ($urandom_range(0, 99) < 5);
      mode_up     = 1'($urandom);
      auto_reload = 1'($urandom);
      kind        = int'($urandom_range(0, 9));
      if (kind == 0) begin
        hour_bcd_in = 8'($urandom); minute_bcd_in = 8'($urandom); second_bcd_in = 8'($urandom);
      end else if (kind == 1) begin
        {hour_bcd_in, minute_bcd_in, second_bcd_in} = secs_to_bcd(MAXS - int'($urandom_range(0, 3)));
      end else begin
        {hour_bcd_in, minute_bcd_in, second_bcd_in} = secs_to_bcd(int'($urandom_range(0, 4)));
      end
      cyc();
      total++;
      if (dut_disp !== secs_to_bcd(m_disp)) begin
        bad++; $display("FAIL rand_display@%0d: got %h expected %h", n, dut_disp, secs_to_bcd(m_disp));
      end
      total++;
      if (ring !== exp_ring() || any_ring !== (|exp_ring())) begin
        bad++; $display("FAIL rand_ring@%0d: got %b/%b expected %b", n, ring, any_ring, exp_ring());
      end
      total++;
      if (counting !== exp_counting()) begin
        bad++; $display("FAIL rand_counting@%0d: got %b expected %b", n, counting, exp_counting());
      end
      total++;
      if (set_err !== m_err) begin
        bad++; $display("FAIL rand_set_err@%0d: got %b expected %b", n, set_err, m_err);
      end
    end
    set = 1'b0; play = 1'b0; stop = 1'b0; ring_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    pulse_set(0, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0);
    pulse_play(0);
    repeat (15) cyc();
    total++;
    if (counting[0] !== 1'b1) begin bad++; $display("FAIL areset_pre_run: got %b expected 1", counting[0]); end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_disp !== 24'h0 || ring !== '0 || counting !== '0 || any_ring !== 1'b0 || set_err !== 1'b0) begin
      bad++; $display("FAIL areset_outputs: got disp=%h ring=%b counting=%b any=%b err=%b expected zeros",
                      dut_disp, ring, counting, any_ring, set_err);
    end
    model_reset();
    @(posedge clk_50M); #1;
    rst_n = 1'b1;
    repeat (2 * TD) cyc();
    total++;
    if (counting !== '0 || dut_disp !== 24'h0) begin
      bad++; $display("FAIL areset_restart_idle: got counting=%b disp=%h expected 0 000000", counting, dut_disp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ch_sel = '0; set = 1'b0; play = 1'b0; stop = 1'b0; ring_clr = 1'b0;
    mode_up = 1'b0; auto_reload = 1'b0;
    hour_bcd_in = 8'h00; minute_bcd_in = 8'h00; second_bcd_in = 8'h00;
    model_reset();
    test_reset();
    test_countdown();
    test_borrow();
    test_count_up();
    test_auto_reload();
    test_independent();
    test_invalid_set();
    test_same_cycle();
    test_play_zero();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_timer.md
# multi_channel_timer

Parametrised multi-channel hh:mm:ss timer that generalises the single-channel countdown timer in the clock design. It provides CHANNELS independent channels. Each channel runs in countdown or count-up (stopwatch) mode, with optional auto-reload in countdown mode. Each channel has its own ring and counting flags. One command port and one BCD display port are shared by all channels and multiplexed by a channel select, and the block sits between the keypad/menu controller and the seven-segment display driver.

## Interface
- CHANNELS, 4, number of independent timer channels (1-16)
- TICK_DIV, 50_000_000, clk_50M cycles per one-second tick
- SEL_W, 2, width of ch_sel; must be at least ceil(log2(CHANNELS)), minimum 1
- clk_50M  input  1  system clock
- rst_n  input  1  reset: asynchronous, active-low; clock: clk_50M
- ch_sel  input  SEL_W  channel addressed by commands and shown on the display outputs
- set  input  1  one-cycle pulse: load the BCD inputs and mode into the selected channel
- play  input  1  one-cycle pulse: start or resume the selected channel
- stop  input  1  one-cycle pulse: pause the selected channel
- ring_clr  input  1  one-cycle pulse: clear ring of the selected channel
- mode_up  input  1  captured on set; 0 = countdown, 1 = count-up
- auto_reload  input  1  captured on set; countdown only: reload and continue at zero
- hour_bcd_in, minute_bcd_in, second_bcd_in  input  8 each  load value in BCD; hours 00-99, minutes and seconds 00-59
- hour_out_bcd, minute_out_bcd, second_out_bcd  output  8 each  registered value of channel ch_sel
- ring  output  CHANNELS  per-channel ring flag
- counting  output  CHANNELS  per-channel running flag
- any_ring  output  1  OR of ring
- set_err  output  1  one-cycle pulse on a rejected set

## Operation
- Channel storage:
  - Each channel holds six BCD digit counters for the current value, a copy of the load value, the mode_up and reload bits, and a 2-bit state: IDLE, RUN, PAUSE, DONE.
  - There is no binary-to-BCD division path.
- Prescaler: free-running 0..TICK_DIV-1. tick is a one-cycle internal pulse when the count equals TICK_DIV-1.
- Command decode applies only to channel ch_sel. Priority is set > stop > play. ring_clr is independent and acts in the same cycle as any of them.
- set:
  - If any digit is >9, minutes >59, or seconds >59: the channel is unchanged and set_err pulses.
  - Otherwise: load value and copy, capture mode_up and auto_reload, clear ring, state goes to IDLE.
- play:
  - From IDLE or PAUSE, the state goes to RUN.
  - Exception: countdown with value 00:00:00 goes to DONE and sets ring.
  - play is ignored in RUN or DONE.
- stop: RUN goes to PAUSE; ignored in any other state.
- On tick, each RUN channel steps once.
- Countdown step:
  - BCD decrement with borrow: ss 00 goes to 59 with a borrow into mm, mm 00 goes to 59 with a borrow into hh.
  - If the result is 00:00:00: ring is set.
    - If reload=1: value gets the load copy and the state stays RUN.
    - If reload=1 and the copy is zero: state goes to DONE instead.
    - Otherwise: state goes to DONE.
- Count-up step: BCD increment with carry. Reaching 99:59:59 sets ring and the state goes to DONE; the value saturates and never wraps.
- counting[i] = 1 exactly when channel i is in RUN.
- ring[i] stays set until set or ring_clr on that channel. A ring occurring in the same cycle as ring_clr wins.
- Display outputs register the value of channel ch_sel every cycle.

## Timing
- Reset values:
  - All outputs are 0.
  - Every channel is IDLE with value, copy, mode and reload all 0.
  - The prescaler is 0.
- Commands take effect at the clk_50M edge where they are sampled. State, counting and ring are visible 1 cycle after the pulse.
- Display latency is 1 cycle after a value change or a ch_sel change.
- The first step after play occurs at the next tick. Phase is not reset, so the first step comes 1 to TICK_DIV cycles later.
- tick coinciding with a command on the same channel:
  - The command wins and no step occurs for that channel in that cycle.
  - Other channels step normally.
- ring asserts in the same cycle that the step reaching the terminal value is registered.
- Asynchronous reset mid-run clears everything immediately. Operation restarts from IDLE after rst_n deasserts.

## Test plan
- TICK_DIV=10. Set ch0 to 00:00:03 in countdown mode, then play:
  - Display shows 02, 01, 00 at 10-cycle intervals.
  - ring[0] and any_ring go to 1 with the 00 value.
  - counting[0] drops to 0.
  - Display holds 00:00:00.
- Borrow chain: set 01:00:00 countdown, play, 1 tick -> 00:59:59.
- Count-up:
  - From 00:00:59, 1 tick -> 00:01:00.
  - From 99:59:58, 1 tick -> 99:59:59, ring=1, DONE; further ticks do not change the value.
- Auto-reload: load 00:00:02 with reload=1, run 5 ticks:
  - Values are 01, 00(reload to 02), 01, 00(02), 01.
  - counting stays 1 and ring=1 after the first zero.
- Independent channels:
  - ch1 counts down from 00:00:05 and ch2 counts up from 0.
  - stop ch1 issued on a tick cycle -> ch1 frozen at its value, ch2 still increments.
  - ring_clr on ch1 has no effect on ch2.
- Invalid set of minutes 0x60 -> set_err pulses 1 cycle and the channel value is unchanged.
- rst_n low mid-run -> all outputs 0 immediately.
- set and play in the same cycle -> load only, state IDLE.
- play at 00:00:00 in countdown -> ring next cycle.
